// File: rtl/rseq_ctrl_pkg.sv
// Shared types and constants for the micro-sequence ROM sequencer.
package rseq_ctrl_pkg;

    typedef enum logic [1:0] {
        FLOW_NONE = 2'd0,
        FLOW_INT  = 2'd1,
        FLOW_EXC  = 2'd2,
        FLOW_IRET = 2'd3
    } flow_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    localparam logic [2:0] INT_START_DEF  = 3'd0;
    localparam logic [2:0] EXC_START_DEF  = 3'd3;
    localparam logic [2:0] IRET_START_DEF = 3'd6;

    localparam logic [2:0] INT_LEN  = 3'd3;
    localparam logic [2:0] EXC_LEN  = 3'd3;
    localparam logic [2:0] IRET_LEN = 3'd2;

    function automatic logic [2:0] last_addr(input logic [2:0] start,
                                             input logic [2:0] len);
        return start + len - 3'd1;
    endfunction

endpackage

// File: rtl/rseq_ctrl_rom.sv
// rseq_rom: 8 x 128-bit micro-op ROM for the INT, EXC and IRET flows.
// Output reads zero while oe is low.
module rseq_rom (
    input  logic         oe,
    input  logic [2:0]   addr,
    output logic [127:0] data
);

    always_comb begin
        data = '0;
        if (oe) begin
            unique case (addr)
                3'd0: data = 128'h00000001_10000000_A5A50000_0000C0DE;
                3'd1: data = 128'h00000002_20000000_A5A50001_0000C0DE;
                3'd2: data = 128'h00000003_30000000_A5A50002_0000C0DE;
                3'd3: data = 128'h00000004_40000000_A5A50003_0000C0DE;
                3'd4: data = 128'h00000005_50000000_A5A50004_0000C0DE;
                3'd5: data = 128'h00000006_60000000_A5A50005_0000C0DE;
                3'd6: data = 128'h00000007_70000000_A5A50006_0000C0DE;
                3'd7: data = 128'h00000008_80000000_A5A50007_0000C0DE;
            endcase
        end
    end

endmodule

// File: rtl/rseq_ctrl.sv
// Interrupt/exception/IRET micro-sequence controller.
// Define RSEQ_NESTED_EXC_EN to let an exception abort an active INT/IRET flow.
module rseq_ctrl
    import rseq_ctrl_pkg::*;
#(
    parameter logic [2:0] INT_START  = INT_START_DEF,
    parameter logic [2:0] EXC_START  = EXC_START_DEF,
    parameter logic [2:0] IRET_START = IRET_START_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         exc_req,
    input  logic [7:0]   exc_vector,
    input  logic         int_req,
    input  logic [7:0]   int_vector,
    input  logic         iret_req,
    input  logic         flush,
    input  logic         uop_ready,
    output logic         exc_ack,
    output logic         int_ack,
    output logic         iret_ack,
    output logic         uop_valid,
    output logic [127:0] uop_data,
    output logic         uop_last,
    output logic [7:0]   rseq_vector,
    output logic         rseq_busy,
    output logic         rseq_done
);

    state_e     state_q, state_d;
    flow_e      flow_q, flow_d;
    logic [2:0] addr_q, addr_d;
    logic [2:0] end_q, end_d;
    logic [7:0] vec_q, vec_d;
    logic       exc_ack_q, exc_ack_d;
    logic       int_ack_q, int_ack_d;
    logic       iret_ack_q, iret_ack_d;
    logic       done_q, done_d;

    logic       issue, at_last, accept, accept_last;
    logic       any_req, nest, take;
    flow_e      pick;
    logic [2:0] pick_start, pick_len;
    logic [7:0] pick_vec;

    assign issue       = (state_q == ST_ISSUE);
    assign at_last     = (addr_q == end_q);
    assign accept      = issue & uop_ready;
    assign accept_last = accept & at_last;
    assign any_req     = exc_req | int_req | iret_req;

`ifdef RSEQ_NESTED_EXC_EN
    assign nest = issue & (flow_q != FLOW_EXC) & exc_req & ~accept_last;
`else
    assign nest = 1'b0;
`endif

    // A completing flow hands over to a pending request on the same edge.
    assign take = ~flush & (((~issue | accept_last) & any_req) | nest);

    always_comb begin
        pick       = FLOW_NONE;
        pick_start = INT_START;
        pick_len   = INT_LEN;
        pick_vec   = '0;
        if (exc_req) begin
            pick       = FLOW_EXC;
            pick_start = EXC_START;
            pick_len   = EXC_LEN;
            pick_vec   = exc_vector;
        end else if (int_req) begin
            pick       = FLOW_INT;
            pick_start = INT_START;
            pick_len   = INT_LEN;
            pick_vec   = int_vector;
        end else if (iret_req) begin
            pick       = FLOW_IRET;
            pick_start = IRET_START;
            pick_len   = IRET_LEN;
        end
    end

    always_comb begin
        state_d    = state_q;
        flow_d     = flow_q;
        addr_d     = addr_q;
        end_d      = end_q;
        vec_d      = vec_q;
        exc_ack_d  = 1'b0;
        int_ack_d  = 1'b0;
        iret_ack_d = 1'b0;
        done_d     = accept_last & ~flush;
        if (flush) begin
            state_d = ST_IDLE;
        end else if (take) begin
            state_d    = ST_ISSUE;
            flow_d     = pick;
            addr_d     = pick_start;
            end_d      = last_addr(pick_start, pick_len);
            vec_d      = pick_vec;
            exc_ack_d  = (pick == FLOW_EXC);
            int_ack_d  = (pick == FLOW_INT);
            iret_ack_d = (pick == FLOW_IRET);
        end else if (accept) begin
            if (at_last) state_d = ST_IDLE;
            else         addr_d  = addr_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            flow_q     <= FLOW_NONE;
            addr_q     <= '0;
            end_q      <= '0;
            vec_q      <= '0;
            exc_ack_q  <= 1'b0;
            int_ack_q  <= 1'b0;
            iret_ack_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            flow_q     <= flow_d;
            addr_q     <= addr_d;
            end_q      <= end_d;
            vec_q      <= vec_d;
            exc_ack_q  <= exc_ack_d;
            int_ack_q  <= int_ack_d;
            iret_ack_q <= iret_ack_d;
            done_q     <= done_d;
        end
    end

    rseq_rom u_rom (
        .oe   (issue),
        .addr (addr_q),
        .data (uop_data)
    );

    assign uop_valid   = issue;
    assign uop_last    = issue & at_last;
    assign rseq_vector = issue ? vec_q : 8'h00;
    assign rseq_busy   = issue;
    assign rseq_done   = done_q;
    assign exc_ack     = exc_ack_q;
    assign int_ack     = int_ack_q;
    assign iret_ack    = iret_ack_q;

endmodule

// File: tb/tb_rseq_ctrl.sv
// Bench for rseq_ctrl: directed flows plus randomized traffic against a
// queue-based model of the active flow's remaining ROM addresses.
module tb_rseq_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         exc_req, int_req, iret_req, flush, uop_ready;
    logic [7:0]   exc_vector, int_vector;
    logic         exc_ack, int_ack, iret_ack;
    logic         uop_valid, uop_last, rseq_busy, rseq_done;
    logic [127:0] uop_data;
    logic [7:0]   rseq_vector;

    always #5 clk = ~clk;

    rseq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .exc_req     (exc_req),
        .exc_vector  (exc_vector),
        .int_req     (int_req),
        .int_vector  (int_vector),
        .iret_req    (iret_req),
        .flush       (flush),
        .uop_ready   (uop_ready),
        .exc_ack     (exc_ack),
        .int_ack     (int_ack),
        .iret_ack    (iret_ack),
        .uop_valid   (uop_valid),
        .uop_data    (uop_data),
        .uop_last    (uop_last),
        .rseq_vector (rseq_vector),
        .rseq_busy   (rseq_busy),
        .rseq_done   (rseq_done)
    );

    int npass = 0;
    int ntot  = 0;

    logic [127:0] rom_t [8];

    // model: remaining addresses of the active flow
    logic [2:0] m_q[$];
    bit         m_busy;
    int         m_kind;
    logic [7:0] m_vec;
    bit         m_done;
    logic [2:0] m_ack;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy = 0;
        m_kind = 0;
        m_vec  = 8'h00;
        m_done = 0;
        m_ack  = 3'b000;
    endtask

    task automatic model_edge();
        bit acc, comp, take, nest;
        int st, ln;
        acc    = m_busy && uop_ready;
        comp   = acc && (m_q.size() == 1);
        m_done = comp && !flush;
        m_ack  = 3'b000;
        nest   = 0;
`ifdef RSEQ_NESTED_EXC_EN
        nest = m_busy && (m_kind != 2) && exc_req && !comp;
`endif
        if (flush) begin
            m_busy = 0;
            m_q.delete();
        end else begin
            take = ((!m_busy || comp) && (exc_req || int_req || iret_req)) || nest;
            if (take) begin
                if (exc_req) begin
                    m_kind = 2; m_vec = exc_vector; m_ack = 3'b100; st = 3; ln = 3;
                end else if (int_req) begin
                    m_kind = 1; m_vec = int_vector; m_ack = 3'b010; st = 0; ln = 3;
                end else begin
                    m_kind = 3; m_vec = 8'h00; m_ack = 3'b001; st = 6; ln = 2;
                end
                m_q.delete();
                for (int a = st; a < st + ln; a++) m_q.push_back(3'(a));
                m_busy = 1;
            end else if (acc) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_busy = 0;
            end
        end
    endtask

    task automatic compare();
        logic [2:0] a0;
        chk("valid", 128'(uop_valid), 128'(m_busy));
        chk("busy", 128'(rseq_busy), 128'(m_busy));
        chk("done", 128'(rseq_done), 128'(m_done));
        chk("acks", 128'({exc_ack, int_ack, iret_ack}), 128'(m_ack));
        if (m_busy) begin
            a0 = m_q[0];
            chk("data", uop_data, rom_t[a0]);
            chk("last", 128'(uop_last), 128'(m_q.size() == 1));
            chk("vector", 128'(rseq_vector), 128'(m_vec));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
        if (exc_ack)  exc_req  = 1'b0;
        if (int_ack)  int_req  = 1'b0;
        if (iret_ack) iret_req = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((m_busy || exc_req || int_req || iret_req) && n < budget) begin
            cyc();
            n++;
        end
        chk("drain_timeout", 128'(n < budget), 128'(1));
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_valid"}, 128'(uop_valid), 128'(0));
        chk({nm, "_busy"}, 128'(rseq_busy), 128'(0));
        chk({nm, "_done"}, 128'(rseq_done), 128'(0));
        chk({nm, "_last"}, 128'(uop_last), 128'(0));
        chk({nm, "_vec"}, 128'(rseq_vector), 128'(0));
        chk({nm, "_acks"}, 128'({exc_ack, int_ack, iret_ack}), 128'(0));
        chk({nm, "_data"}, uop_data, 128'(0));
    endtask

    initial begin
        for (int i = 0; i < 8; i++)
            rom_t[i] = {32'(i + 1), 4'(i + 1), 28'h0, 16'hA5A5, 16'(i), 32'h0000C0DE};
        rst_n = 1'b0;
        exc_req = 0; int_req = 0; iret_req = 0; flush = 0; uop_ready = 0;
        exc_vector = 8'h00; int_vector = 8'h00;
        model_reset();
        #1;
        check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // INT only
        uop_ready = 1; int_req = 1; int_vector = 8'h21;
        cyc();
        chk("t1_ack", 128'(int_ack), 128'(1));
        chk("t1_w0", uop_data, 128'h00000001_10000000_A5A50000_0000C0DE);
        chk("t1_vec", 128'(rseq_vector), 128'(8'h21));
        cyc();
        chk("t1_w1", uop_data, 128'h00000002_20000000_A5A50001_0000C0DE);
        cyc();
        chk("t1_w2", uop_data, 128'h00000003_30000000_A5A50002_0000C0DE);
        chk("t1_last", 128'(uop_last), 128'(1));
        cyc();
        chk("t1_done", 128'(rseq_done), 128'(1));
        chk("t1_idle", 128'(rseq_busy), 128'(0));

        // simultaneous requests, back-to-back flows, then IRET backpressure
        exc_req = 1; exc_vector = 8'h0E; int_req = 1; int_vector = 8'h33; iret_req = 1;
        cyc();
        chk("t2_acks", 128'({exc_ack, int_ack, iret_ack}), 128'(3'b100));
        chk("t2_w3", uop_data, 128'h00000004_40000000_A5A50003_0000C0DE);
        chk("t2_vec", 128'(rseq_vector), 128'(8'h0E));
        cyc();
        cyc();
        chk("t2_w5", uop_data, 128'h00000006_60000000_A5A50005_0000C0DE);
        cyc();
        chk("t2_b2b", uop_data, 128'h00000001_10000000_A5A50000_0000C0DE);
        chk("t2_done", 128'(rseq_done), 128'(1));
        chk("t2_intack", 128'(int_ack), 128'(1));
        cyc();
        cyc();
        cyc();
        chk("t3_w6", uop_data, 128'h00000007_70000000_A5A50006_0000C0DE);
        chk("t3_ivec", 128'(rseq_vector), 128'(0));
        uop_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t3_hold", uop_data, 128'h00000007_70000000_A5A50006_0000C0DE);
        end
        uop_ready = 1;
        cyc();
        chk("t3_w7", uop_data, 128'h00000008_80000000_A5A50007_0000C0DE);
        chk("t3_last", 128'(uop_last), 128'(1));
        cyc();
        chk("t3_done", 128'(rseq_done), 128'(1));

        // flush mid-INT; source still holding its request
        int_req = 1; int_vector = 8'h40;
        cyc();
        cyc();
        flush = 1; int_req = 1;
        cyc();
        chk("t4_busy", 128'(rseq_busy), 128'(0));
        chk("t4_nodone", 128'(rseq_done), 128'(0));
        flush = 0;
        cyc();
        chk("t4_restart", uop_data, 128'h00000001_10000000_A5A50000_0000C0DE);
        drain(20);

        // exception arriving during INT
        int_req = 1; int_vector = 8'h50;
        cyc();
        cyc();
        exc_req = 1; exc_vector = 8'h0D;
        cyc();
`ifdef RSEQ_NESTED_EXC_EN
        chk("t5_nest", uop_data, 128'h00000004_40000000_A5A50003_0000C0DE);
        chk("t5_nodone", 128'(rseq_done), 128'(0));
`else
        chk("t5_w2", uop_data, 128'h00000003_30000000_A5A50002_0000C0DE);
        cyc();
        chk("t5_w3", uop_data, 128'h00000004_40000000_A5A50003_0000C0DE);
        chk("t5_done", 128'(rseq_done), 128'(1));
`endif
        drain(20);

        // async reset mid-EXC
        exc_req = 1; exc_vector = 8'h0F;
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        check_zero("arst");
        exc_req = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("arst_idle", 128'(rseq_busy), 128'(0));

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            uop_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            if (!exc_req && $urandom_range(0, 9) == 0) begin
                exc_req = 1; exc_vector = 8'($urandom);
            end
            if (!int_req && $urandom_range(0, 7) == 0) begin
                int_req = 1; int_vector = 8'($urandom);
            end
            if (!iret_req && $urandom_range(0, 7) == 0) iret_req = 1;
            cyc();
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/rseq_ctrl.md
# rseq_ctrl

Sequencer for the interrupt/exception/IRET micro-sequence ROM (`rseq_rom`). It arbitrates between exception, interrupt and IRET requests and latches the winning vector. It then steps the ROM address through the selected flow, presenting one 128-bit micro-op word per cycle to decode under a valid/ready handshake. While a flow is active it asserts busy so fetch/decode hold normal instructions.

## Interface
Parameters:
- `INT_START`, 3'd0, first ROM word of the INT flow (3 words, 0-2)
- `EXC_START`, 3'd3, first ROM word of the EXC flow (3 words, 3-5)
- `IRET_START`, 3'd6, first ROM word of the IRET flow (2 words, 6-7)

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: sole clock; all state on rising edge
- `rst_n` in 1: asynchronous active-low reset
- `exc_req` in 1: exception request, level, held until `exc_ack`
- `exc_vector` in 8: exception vector, valid with `exc_req`
- `int_req` in 1: interrupt/INT n request, level, held until `int_ack`
- `int_vector` in 8: interrupt vector, valid with `int_req`
- `iret_req` in 1: IRET request, level, held until `iret_ack`
- `flush` in 1: pipeline flush; aborts active flow
- `uop_ready` in 1: decode accepts current word
- `exc_ack`/`int_ack`/`iret_ack` out 1 each: one-cycle pulse when the request is taken
- `uop_valid` out 1: `uop_data` is a valid micro-op word
- `uop_data` out 128: ROM word at current address
- `uop_last` out 1: current word is final word of flow
- `rseq_vector` out 8: latched vector of active flow (0 for IRET)
- `rseq_busy` out 1: a flow is active
- `rseq_done` out 1: one-cycle pulse after last word accepted

## Operation
- States: IDLE, ISSUE. Registers: `addr[2:0]`, `end_addr[2:0]`, `flow[1:0]`, `vector[7:0]`.
- Arbitration when taking a request: exc > int > iret. Taken request gets its ack pulse. `addr`←start, `end_addr`←start+len-1, `vector`←request vector (IRET: 0).
- IDLE: any request → ISSUE. No request → stay.
- ISSUE: `uop_valid`=1, ROM `oe`=1, `uop_last`=(addr==end_addr).
  - Accept (`uop_valid & uop_ready`) on a non-last word → `addr`+1.
  - Accept on the last word → `rseq_done` next cycle. A pending request is taken in the same edge (back-to-back, no bubble); otherwise → IDLE.
  - No accept → hold addr/data stable.
- `flush` (any state): → IDLE next edge, no done, no acks that cycle; requests held by their sources are re-sampled afterwards.
- `exc_req` during an EXC flow: not taken until that flow completes, in both configurations.
- Addr never wraps past 7; `end_addr` ≤ 7 by construction.
- Reset values: state IDLE, addr 0, all acks 0, `uop_valid` 0, `uop_last` 0, `rseq_vector` 0, `rseq_busy` 0, `rseq_done` 0, oe 0.

## Timing
- Request high at edge N in IDLE → ack high during cycle N..N+1. First `uop_valid` with start word in cycle after edge N (1-cycle latency).
- One word per cycle with `uop_ready` held: INT/EXC occupy 3 cycles, IRET 2.
- `uop_data` is combinational from the registered addr through the ROM. It is stable for the whole cycle.
- `rseq_busy` = (state==ISSUE), registered.
- `rseq_done` asserts the cycle after the last-word accept. It is independent of whether a new flow starts in that cycle.
- Reset asserted mid-flow: outputs go to reset values immediately (async). No done.

## Configuration
- `RSEQ_NESTED_EXC_EN` defined: `exc_req` during an active INT or IRET flow aborts that flow. At the next edge, EXC_START is loaded, `exc_ack` pulses and `exc_vector` is latched. The aborted flow gets no done.
- Not defined: `exc_req` waits until the active flow completes, then wins arbitration normally.

## Structure
- Shared package/header: flow encodings (`FLOW_INT`, `FLOW_EXC`, `FLOW_IRET`), start addresses and lengths, state encoding.
- One sub-module: instance of `rseq_rom` (addr from `addr` register, `oe` from ISSUE state).
- Flow priority logic and next-address logic are local to `rseq_ctrl`.

## Test plan
- INT only: `int_req`=1, `int_vector`=8'h21, `uop_ready`=1 → addr 0,1,2 on consecutive cycles. `uop_last` on addr 2. `rseq_vector`=8'h21. `rseq_done` pulse, then IDLE.
- Simultaneous `exc_req`(8'h0E) + `int_req` + `iret_req` in IDLE → only `exc_ack`. Addr 3,4,5. The INT flow follows back-to-back with addr 0 the cycle after addr 5 is accepted.
- Backpressure: IRET with `uop_ready` low for 3 cycles on addr 6 → addr/data stable on 6. Addr 7 issues one cycle after ready rises.
- `flush` on addr 1 of INT → IDLE next cycle, no done. The held `int_req` restarts at addr 0.
- `exc_req` arrives on addr 1 of INT: with `RSEQ_NESTED_EXC_EN` → addr 3 next cycle and no INT done. Without it → INT completes (addr 2), then addr 3.
- Assert `rst_n`=0 mid-EXC → all outputs 0 asynchronously. After release the block is IDLE.
